ahb_master_sequencer: RTL

Command-level controller that drives the input side of the AHB master pipeline (the AGU/DO/DI register stages). It accepts one burst command at a time, requests and holds the bus, and issues NONSEQ/SEQ/BUSY/IDLE beats synchronised to the pipeline advance condition. It recovers from RETRY/SPLIT by replaying beats, terminates on ERROR, and reports completion. It sits between the DMA/CPU command source and the pipeline; the AHB inputs are shared with the pipeline.

---
 rtl/ahb_master_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ahb_master_sequencer.sv
// ahb_master_sequencer: turns burst commands into NONSEQ/SEQ/BUSY/IDLE beats for the AHB master pipeline, replaying on RETRY/SPLIT
module ahb_master_sequencer #(
    parameter int         WDT       = 32,
    parameter logic [3:0] MASTER_ID = 4'd4,
    parameter logic [3:0] HPROT     = 4'b0011
) (
    input  logic           i_hclk,
    input  logic           i_hreset,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic [31:0]    i_cmd_addr,
    input  logic [7:0]     i_cmd_len,
    input  logic [1:0]     i_cmd_size,
    input  logic           i_cmd_write,
    input  logic           i_cmd_lock,
    input  logic [WDT-1:0] i_wr_data,
    input  logic           i_wr_valid,
    output logic           o_wr_ready,
    input  logic           i_hready,
    input  logic           i_hgrant,
    input  logic [1:0]     i_hresp,
    input  logic [3:0]     i_hmaster,
    output logic [1:0]     o_htrans,
    output logic [1:0]     o_hsize,
    output logic [31:0]    o_haddr,
    output logic [WDT-1:0] o_hwdata,
    output logic           o_hwrite,
    output logic           o_hlock,
    output logic           o_hbusreq,
    output logic [3:0]     o_hprot,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DRAIN, S_DONE} state_t;
    typedef struct packed {
        logic           vld;
        logic [31:0]    addr;
        logic [8:0]     left;
        logic [WDT-1:0] data;
    } beat_t;
    localparam logic [1:0] MAX_SIZE = 2'($clog2(WDT / 8));
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    state_t         state_q;
    logic [31:0]    cur_addr_q;
    logic [8:0]     left_q;
    logic           first_q, write_q, lock_q, err_q, rdy_q;
    logic [1:0]     size_q, rp_cnt_q;
    logic [WDT-1:0] rp0_q, rp1_q;
    beat_t          a_q, d_q, a_d, d_d;
    logic           adv, in_addr, replay, data_ok, can_issue, issue, fault, retry, error, illegal;
    assign adv       = i_hready && i_hmaster == MASTER_ID;
    assign in_addr   = state_q == S_ADDR;
    assign replay    = rp_cnt_q != 2'd0;
    assign data_ok   = !write_q || replay || i_wr_valid;
    assign can_issue = in_addr && i_hgrant && data_ok;
    assign issue     = can_issue && adv;
    assign fault     = !i_hready && d_q.vld;
    assign retry     = fault && i_hresp[1];
    assign error     = fault && i_hresp == 2'b01;
    assign illegal   = i_cmd_size > MAX_SIZE;
    assign o_htrans    = can_issue ? ((first_q || cur_addr_q[9:0] == 10'd0) ? T_NONSEQ : T_SEQ)
                       : (in_addr && i_hgrant && !first_q) ? T_BUSY : T_IDLE;
    assign o_hwdata    = !in_addr ? '0 : replay ? rp0_q : i_wr_data;
    assign o_wr_ready  = adv && in_addr && i_hgrant && write_q && !replay && i_wr_valid;
    assign o_haddr     = cur_addr_q;
    assign o_hsize     = size_q;
    assign o_hwrite    = write_q;
    assign o_hprot     = HPROT;
    assign o_hlock     = lock_q && (state_q == S_REQ || in_addr || state_q == S_DRAIN);
    assign o_hbusreq   = state_q == S_REQ || (in_addr && left_q > 9'd1);
    assign o_busy      = state_q != S_IDLE;
    assign o_done      = state_q == S_DONE;
    assign o_err       = o_done && err_q;
    assign o_cmd_ready = state_q == S_IDLE && rdy_q;
    always_comb begin
        a_d = a_q;
        d_d = d_q;
        if (adv) begin
            d_d = a_q;
            a_d = '0;
            if (issue) a_d = '{1'b1, cur_addr_q, left_q, o_hwdata};
        end else if (retry) begin
            a_d = '0;
            d_d = '0;
        end
    end
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            left_q     <= '0;
            first_q    <= 1'b0;
            write_q    <= 1'b1;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            size_q     <= '0;
            rp_cnt_q   <= '0;
            rp0_q      <= '0;
            rp1_q      <= '0;
            a_q        <= '0;
            d_q        <= '0;
        end else begin
            rdy_q <= 1'b1;
            a_q   <= a_d;
            d_q   <= d_d;
            if (error) err_q <= 1'b1;
            if (issue) begin
                cur_addr_q <= cur_addr_q + (32'd1 << size_q);
                left_q     <= left_q - 9'd1;
                first_q    <= 1'b0;
                if (replay) begin
                    rp0_q    <= rp1_q;
                    rp_cnt_q <= rp_cnt_q - 2'd1;
                end
            end
            // Rewind to the beat in its data phase; its data and any younger beat's data are replayed first
            if (retry) begin
                cur_addr_q <= d_q.addr;
                left_q     <= d_q.left;
                first_q    <= 1'b1;
                rp0_q      <= d_q.data;
                rp1_q      <= a_q.vld ? a_q.data : rp0_q;
                rp_cnt_q   <= !write_q ? 2'd0 : (a_q.vld || replay) ? 2'd2 : 2'd1;
            end
            case (state_q)
                S_IDLE: if (i_cmd_valid && o_cmd_ready) begin
                    size_q     <= i_cmd_size;
                    write_q    <= i_cmd_write;
                    lock_q     <= i_cmd_lock;
                    cur_addr_q <= i_cmd_addr;
                    left_q     <= {1'b0, i_cmd_len} + 9'd1;
                    first_q    <= 1'b1;
                    err_q      <= illegal;
                    rp_cnt_q   <= '0;
                    state_q    <= illegal ? S_DONE : S_REQ;
                end
                S_REQ: state_q <= error ? S_DRAIN : (adv && i_hgrant) ? S_ADDR : S_REQ;
                S_ADDR: begin
                    if (retry) state_q <= S_REQ;
                    else if (error) state_q <= S_DRAIN;
                    else if (adv && !i_hgrant) begin
                        state_q <= S_REQ;
                        first_q <= 1'b1;
                    end else if (issue && left_q == 9'd1) state_q <= S_DRAIN;
                end
                S_DRAIN: state_q <= retry ? S_REQ : (!a_d.vld && !d_d.vld) ? S_DONE : S_DRAIN;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
